imm_gen_stream: RTL and testbench
=================================

// Module: imm_gen_stream
// PURPOSE
//  Parametrised, pipelined successor to the combinational immediate generator. It decodes the
//  immediate of every RV32I/RV64I format (I, S, B, U, J) to a sign-extended XLEN byte offset.
//  It also reports the detected format and flags opcodes that carry no immediate.
//  It sits between fetch/decode and execute behind a valid/ready stream with a 2-entry skid
//  buffer, so in_ready is a registered signal.
// PARAMETERS
//  XLEN       32  output data width; legal values 32 or 64
//  TAG_WIDTH  32  width of the sideband tag (e.g. PC) carried alongside each instruction
//  CNT_WIDTH  16  width of the saturating illegal-format counter
// PORTS
//  clk            in   1          clock, all state updates on rising edge
//  rst            in   1          synchronous reset, active-high
//  flush          in   1          synchronous flush, drops all buffered entries
//  in_valid       in   1          upstream holds an instruction
//  in_ready       out  1          block can accept; registered (depends only on state)
//  in_instr       in   32         raw instruction word
//  in_tag         in   TAG_WIDTH  sideband, passed through unchanged
//  out_valid      out  1          out_* fields are valid
//  out_ready      in   1          downstream accepts
//  out_offset     out  XLEN       sign-extended immediate (byte offset)
//  out_fmt        out  3          0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//  out_tag        out  TAG_WIDTH  tag of the entry on out_offset
//  out_illegal    out  1          1 when out_fmt == NONE
//  illegal_count  out  CNT_WIDTH  count of accepted NONE-format entries, saturating
// BEHAVIOUR
//  - Format by opcode [6:0]:
//      I = 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR
//      S = 0100011, B = 1100011, U = 0110111 LUI / 0010111 AUIPC, J = 1101111
//      Anything else = NONE: offset 0, out_illegal=1.
//  - Immediates, all sign-extended from instr[31] to XLEN:
//      I {[31:20]}; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],1'b0};
//      U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],1'b0}.
//  - Decode happens at acceptance and is stored with the entry. Latency is 1 cycle: data
//    accepted at edge N appears on out_* after edge N when the buffer was empty.
//  - Handshakes: transfer occurs when valid && ready at a rising edge. out_* stay stable while
//    out_valid && !out_ready. in_instr is don't-care when in_valid=0.
//  - State machine over occupancy:
//      EMPTY -> ONE on accept.
//      ONE   -> ONE on accept && pop; -> TWO on accept && !pop; -> EMPTY on pop && !accept.
//      TWO   -> ONE on pop; no accept is possible in TWO.
//  - in_ready = (state != TWO). out_valid = (state != EMPTY). Order is strictly FIFO; the skid
//    entry moves to the output register on pop.
//  - illegal_count increments by 1 per accepted NONE entry. It holds at 2^CNT_WIDTH-1.
//    It is unaffected by flush.
//  - flush: next state EMPTY, and the input offered in the flush cycle is dropped.
//    The in_ready computed before the edge still applies, so a handshake that completes in the
//    flush cycle is consumed and discarded. An illegal entry dropped this way is not counted.
//  - rst has priority over flush and clears everything:
//      state EMPTY, in_ready=1, out_valid=0, out_offset=0, out_fmt=0, out_tag=0,
//      out_illegal=0, illegal_count=0.
//    Reset mid-stream discards buffered entries without emitting them.
//  - Data registers carry no reset requirement beyond the out_* values above.
// TESTING
//  1. 0xFFC12083 (lw x1,-4(x2)), out_ready=1 -> 1 cycle later out_offset=0xFFFFFFFC, fmt=1.
//  2. 0x00512423 (sw) -> 0x00000008 fmt=2; 0xFE000CE3 (beq -8) -> 0xFFFFFFF8 fmt=3.
//  3. 0x123450B7 (lui) -> 0x12345000 fmt=4; 0x0010006F (jal +2048) -> 0x00000800 fmt=5.
//     With XLEN=64, 0xFFC12083 -> 0xFFFFFFFFFFFFFFFC.
//  4. 0x00000000 -> offset 0, fmt=0, out_illegal=1, illegal_count=1.
//     With CNT_WIDTH=2, five illegal entries -> count saturates at 3.
//  5. Back-to-back stream of tags 1..6, out_ready low for 3 cycles mid-stream -> in_ready drops
//     the cycle after state reaches TWO; tags emerge 1..6 in order, none lost or duplicated,
//     out_* stable while stalled.
//  6. In TWO, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1, the
//     flushed input never appears. Repeat with rst -> all outputs reach reset values.

Source files
------------

// File: rtl/imm_gen_stream.sv
// imm_gen_stream: pipelined RV32I/RV64I immediate decoder.
// It sits behind a valid/ready stream with a 2-entry skid buffer.
// Each instruction is decoded when it is accepted. The decoded offset,
// format and tag then travel together through the head and skid registers.
//
// state | meaning
// EMPTY | no entry held, out_valid=0, in_ready=1
// ONE   | head register holds the oldest entry, skid free
// TWO   | head and skid both full, in_ready=0
module imm_gen_stream #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_offset,
  output logic [2:0]           out_fmt,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                 state;
  logic [31:0]            imm32;
  logic [2:0]             dec_fmt;
  logic [XLEN-1:0]        dec_off;
  logic [XLEN-1:0]        skid_off;
  logic [2:0]             skid_fmt;
  logic [TAG_WIDTH-1:0]   skid_tag;
  logic                   accept;
  logic                   pop;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // Decode the offered instruction to its format and sign-extended offset.
  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_NONE;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec_fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      default: begin
        dec_fmt = FMT_NONE;
        imm32   = '0;
      end
    endcase
    // XLEN-31 copies of bit 31 plus bits 30:0 keeps the replication non-zero at XLEN=32.
    dec_off = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
  end

  // Skid entry is written only when an accept arrives while the head is held.
  always_ff @(posedge clk) begin
    if (state == ONE && accept && !pop) begin
      skid_off <= dec_off;
      skid_fmt <= dec_fmt;
      skid_tag <= in_tag;
    end
  end

  // Saturating count of accepted NONE-format entries; flushed inputs are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_count <= '0;
    end else if (accept && !flush && dec_fmt == FMT_NONE && illegal_count != '1) begin
      illegal_count <= illegal_count + CNT_WIDTH'(1);
    end
  end

  // Occupancy FSM with registered handshake flags and head (output) register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_offset  <= '0;
      out_fmt     <= FMT_NONE;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_offset  <= dec_off;
            out_fmt     <= dec_fmt;
            out_tag     <= in_tag;
            out_illegal <= (dec_fmt == FMT_NONE);
            out_valid   <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            out_offset  <= dec_off;
            out_fmt     <= dec_fmt;
            out_tag     <= in_tag;
            out_illegal <= (dec_fmt == FMT_NONE);
          end else if (accept) begin
            in_ready <= 1'b0;
            state    <= TWO;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            out_offset  <= skid_off;
            out_fmt     <= skid_fmt;
            out_tag     <= skid_tag;
            out_illegal <= (skid_fmt == FMT_NONE);
            in_ready    <= 1'b1;
            state       <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_stream.sv
// Bench for imm_gen_stream: directed vectors, stall/flush/reset scenarios and
// random traffic against a queue-based reference model. A second instance
// (XLEN=64, CNT_WIDTH=2) shares the stimulus to cover 64-bit extension and
// counter saturation.
module tb_imm_gen_stream;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [31:0] out_offset_a, out_tag_a;
  logic [2:0]  out_fmt_a;
  logic [15:0] count_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [63:0] out_offset_b;
  logic [31:0] out_tag_b;
  logic [2:0]  out_fmt_b;
  logic [1:0]  count_b;

  always #5 clk = ~clk;

  imm_gen_stream #(.XLEN(32), .TAG_WIDTH(32), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_offset(out_offset_a), .out_fmt(out_fmt_a), .out_tag(out_tag_a),
    .out_illegal(out_illegal_a), .illegal_count(count_a));

  imm_gen_stream #(.XLEN(64), .TAG_WIDTH(32), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_offset(out_offset_b), .out_fmt(out_fmt_b), .out_tag(out_tag_b),
    .out_illegal(out_illegal_b), .illegal_count(count_b));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] off;
    int          fmt;
    logic [31:0] tag;
  } exp_t;

  exp_t q[$];
  int   cnt_m = 0;
  bit   reset_seen;
  bit   last_acc;
  bit   saw_ready_low;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference decode from the ISA field layout using signed arithmetic.
  function automatic void ref_dec(input logic [31:0] i, output int fmt, output logic [63:0] off);
    int s;
    int imm;
    s   = int'(i);
    imm = 0;
    fmt = 0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin fmt = 1; imm = s >>> 20; end
      7'h23: begin fmt = 2; imm = ((s >>> 25) << 5) | int'(i[11:7]); end
      7'h63: begin
        fmt = 3;
        imm = ((s >>> 31) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
      end
      7'h37, 7'h17: begin fmt = 4; imm = int'(i & 32'hFFFFF000); end
      7'h6F: begin
        fmt = 5;
        imm = ((s >>> 31) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
      end
      default: begin fmt = 0; imm = 0; end
    endcase
    off = 64'(longint'(imm));
  endfunction

  task automatic check_state();
    exp_t f;
    int   ca;
    int   cb;
    check_eq("in_ready_a", {63'b0, in_ready_a}, {63'b0, q.size() < 2});
    check_eq("in_ready_b", {63'b0, in_ready_b}, {63'b0, q.size() < 2});
    check_eq("out_valid_a", {63'b0, out_valid_a}, {63'b0, q.size() > 0});
    check_eq("out_valid_b", {63'b0, out_valid_b}, {63'b0, q.size() > 0});
    if (!in_ready_a) saw_ready_low = 1'b1;
    if (q.size() > 0) begin
      f = q[0];
      check_eq("offset_a", {32'b0, out_offset_a}, {32'b0, f.off[31:0]});
      check_eq("offset_b", out_offset_b, f.off);
      check_eq("fmt_a", {61'b0, out_fmt_a}, 64'(f.fmt));
      check_eq("fmt_b", {61'b0, out_fmt_b}, 64'(f.fmt));
      check_eq("tag_a", {32'b0, out_tag_a}, {32'b0, f.tag});
      check_eq("tag_b", {32'b0, out_tag_b}, {32'b0, f.tag});
      check_eq("illegal_a", {63'b0, out_illegal_a}, {63'b0, f.fmt == 0});
      check_eq("illegal_b", {63'b0, out_illegal_b}, {63'b0, f.fmt == 0});
    end
    if (reset_seen) begin
      check_eq("rst_offset_a", {32'b0, out_offset_a}, 64'd0);
      check_eq("rst_offset_b", out_offset_b, 64'd0);
      check_eq("rst_fmt_a", {61'b0, out_fmt_a}, 64'd0);
      check_eq("rst_tag_a", {32'b0, out_tag_a}, 64'd0);
      check_eq("rst_illegal_a", {63'b0, out_illegal_a}, 64'd0);
      check_eq("rst_illegal_b", {63'b0, out_illegal_b}, 64'd0);
    end
    ca = (cnt_m > 65535) ? 65535 : cnt_m;
    cb = (cnt_m > 3) ? 3 : cnt_m;
    check_eq("count_a", {48'b0, count_a}, 64'(ca));
    check_eq("count_b", {62'b0, count_b}, 64'(cb));
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] tg,
                       input bit ordy, input bit fl, input bit rs);
    exp_t e;
    bit   acc;
    bit   pop;
    rst       = rs;
    flush     = fl;
    in_valid  = v;
    in_instr  = ins;
    in_tag    = tg;
    out_ready = ordy;
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && ordy;
    last_acc = acc && !rs && !fl;
    if (rs) begin
      q.delete();
      cnt_m = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        ref_dec(ins, e.fmt, e.off);
        e.tag = tg;
        q.push_back(e);
        if (e.fmt == 0) cnt_m++;
      end
    end
    reset_seen = rs;
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  logic [31:0] dv_ins[6] = '{32'hFFC12083, 32'h00512423, 32'hFE000CE3,
                             32'h123450B7, 32'h0010006F, 32'h00000000};
  logic [31:0] dv_off[6] = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFF8,
                             32'h12345000, 32'h00000800, 32'h00000000};
  int          dv_fmt[6] = '{1, 2, 3, 4, 5, 0};
  logic [6:0]  ops[9]    = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};

  initial begin
    int          t;
    logic [31:0] r;
    logic [6:0]  op;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_tag = '0;
    @(negedge clk);
    cycle(0, 32'h0, 32'h0, 1, 0, 1);
    cycle(0, 32'h0, 32'h0, 1, 0, 1);

    // Directed decode vectors, one per format plus NONE.
    for (int k = 0; k < 6; k++) begin
      cycle(1, dv_ins[k], 32'(k + 1), 1, 0, 0);
      check_eq("dv_off", {32'b0, out_offset_a}, {32'b0, dv_off[k]});
      check_eq("dv_fmt", {61'b0, out_fmt_a}, 64'(dv_fmt[k]));
      if (k == 0) check_eq("dv_off64", out_offset_b, 64'hFFFFFFFFFFFFFFFC);
    end
    check_eq("dv_illegal", {63'b0, out_illegal_a}, 64'd1);
    check_eq("dv_count1", {48'b0, count_a}, 64'd1);

    // Five more illegal entries: narrow counter saturates at 3.
    for (int k = 0; k < 5; k++) cycle(1, 32'h0, 32'(20 + k), 1, 0, 0);
    check_eq("sat_count_b", {62'b0, count_b}, 64'd3);
    check_eq("sat_count_a", {48'b0, count_a}, 64'd6);
    cycle(0, 32'h0, 32'h0, 1, 0, 0);

    // Back-to-back tags 1..6 with a 3-cycle downstream stall.
    saw_ready_low = 1'b0;
    t = 1;
    for (int c = 0; c < 50 && t <= 6; c++) begin
      cycle(1, {12'(t), 13'h0, 7'h13}, 32'(t), !(c >= 2 && c < 5), 0, 0);
      if (last_acc) t++;
    end
    check_eq("stream_done", 64'(t), 64'd7);
    check_eq("stream_ready_low", {63'b0, saw_ready_low}, 64'd1);
    for (int c = 0; c < 3; c++) cycle(0, 32'h0, 32'h0, 1, 0, 0);

    // Flush while full, together with an offered (illegal) input.
    cycle(1, 32'h00100093, 32'd100, 0, 0, 0);
    cycle(1, 32'h00200093, 32'd101, 0, 0, 0);
    check_eq("two_ready", {63'b0, in_ready_a}, 64'd0);
    cycle(1, 32'h00000000, 32'd102, 0, 1, 0);
    check_eq("flush_valid", {63'b0, out_valid_a}, 64'd0);
    check_eq("flush_ready", {63'b0, in_ready_a}, 64'd1);
    cycle(0, 32'h0, 32'h0, 1, 0, 0);
    cycle(0, 32'h0, 32'h0, 1, 0, 0);

    // Reset while full.
    cycle(1, 32'h00100093, 32'd110, 0, 0, 0);
    cycle(1, 32'h00200093, 32'd111, 0, 0, 0);
    cycle(1, 32'h00300093, 32'd112, 0, 0, 1);
    check_eq("rst_count", {48'b0, count_a}, 64'd0);
    cycle(0, 32'h0, 32'h0, 1, 0, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      r  = $urandom();
      op = ops[$urandom_range(0, 8)];
      if (op == 7'h00) op = r[6:0];
      cycle($urandom_range(0, 3) != 0, {r[31:7], op}, $urandom(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0,
            $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
